score_keeper: RTL and testbench
===============================

Name: score_keeper

Overview:
- Registered, parametrised successor to the two-player comparator score counter.
- Consumes a per-round 2-bit comparator verdict and keeps both players' scores, a round count, and a snapshot of player-1 score at the last tie.
- Detects match end at a programmable target score through a two-state FSM.
- Sits between the comparator stage and the display/LED driver.

Parameters:
- CNT_W, 4: width of every score and round counter.
- TARGET, 9: score that ends the match; 0 disables match end (endless play).
- SAT, 1: 1 = counters saturate at all-ones; 0 = counters wrap modulo 2^CNT_W.
- EDGE, 1: 1 = one round per rising edge of comp_valid; 0 = one round per cycle comp_valid is high.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- comp_out, input, 2: verdict. 10 = player 1 point, 01 = player 2 point, 00 = tie, 11 = invalid.
- comp_valid, input, 1: verdict qualifier.
- clear, input, 1: synchronous match restart.
- cnt1, output, CNT_W: player 1 score.
- cnt2, output, CNT_W: player 2 score.
- cnt, output, CNT_W: cnt1 value captured at the last tie, before that tie's increment.
- rounds, output, CNT_W: accepted rounds, invalid verdicts excluded.
- winner, output, 2: 10 = player 1, 01 = player 2, 11 = both reached TARGET on the same round, 00 = none.
- match_over, output, 1: high in state OVER.
- err, output, 1: one-cycle pulse on an accepted event carrying comp_out = 11.

Behaviour:
- Reset: one clock, reset is asynchronous and active-high.
  - cnt1, cnt2, cnt, rounds = 0; winner = 00; match_over = 0; err = 0.
  - State = PLAY; valid_q = 1, so a comp_valid held high through reset does not fire an event.
- Event definition:
  - EDGE=1: ev = comp_valid & ~valid_q, with valid_q updated every cycle.
  - EDGE=0: ev = comp_valid.
- Latency: every output is registered. The effect of an event sampled at edge k is visible immediately after edge k.
- FSM states:
  - PLAY: events update counters.
  - OVER: events ignored, err included; valid_q still tracks comp_valid.
  - PLAY -> OVER when TARGET != 0 and the post-update cnt1 or cnt2 equals TARGET. winner is set in the same edge.
  - OVER -> PLAY only on clear.
- Update rules in PLAY when ev:
  - 10: cnt1+1; rounds+1.
  - 01: cnt2+1; rounds+1.
  - 00: cnt <= old cnt1; cnt1+1; cnt2+1; rounds+1.
  - 11: no counter change; err = 1 for one cycle.
- Width rules:
  - All increments are CNT_W bits.
  - SAT=1: all-ones holds.
  - SAT=0: wraps to 0. A wrap never triggers match end unless the post-wrap value equals TARGET.
- Simultaneous events:
  - clear with ev: clear wins. Counters, cnt, rounds = 0; winner = 00; state = PLAY; the event is discarded.
  - Tie taking both players to TARGET: winner = 11.
  - Tie taking one player to TARGET: that player only.
- Reset mid-round: asynchronous clear of all state. The next event requires a fresh comp_valid rise (EDGE=1).
- TARGET must be <= 2^CNT_W - 1; this is checked by an elaboration assertion.

Decomposition:
- Package score_pkg holds:
  - verdict constants V_P1 = 2'b10, V_P2 = 2'b01, V_TIE = 2'b00, V_BAD = 2'b11;
  - FSM state encoding PLAY = 0, OVER = 1;
  - winner codes.
- Sub-module sat_counter (parameters W, SAT; inputs inc and clr; output q) is instantiated for cnt1, cnt2 and rounds.
- Edge detect and the FSM stay in score_keeper.

Test Plan:
- Reset release with comp_valid held high, EDGE=1 -> no event; all outputs 0 until comp_valid drops and rises again.
- Pulses 10, 10, 01, 00 -> cnt1 = 3, cnt2 = 2, cnt = 2, rounds = 4, err never set. Each update is visible after its sampling edge.
- Default params, nine 10 pulses -> after the ninth, cnt1 = 9, winner = 10, match_over = 1. A further 01 pulse leaves cnt2 = 0 and rounds = 9.
- cnt1 = cnt2 = 8, tie pulse -> cnt1 = cnt2 = 9, cnt = 8, winner = 11.
- TARGET = 0 with 17 pulses of 10:
  - SAT=1 -> cnt1 = 15, rounds = 15;
  - SAT=0 -> cnt1 = 1, rounds = 1.
- Verdict 11 -> err pulse of one cycle, counters unchanged. Then clear asserted in the same cycle as a 10 event -> all zero, PLAY, event dropped.

Source files
------------

// File: rtl/score_pkg.sv
// score_pkg: verdict encodings, FSM states and winner codes shared by the score keeper.
package score_pkg;
   localparam logic [1:0] V_P1  = 2'b10;
   localparam logic [1:0] V_P2  = 2'b01;
   localparam logic [1:0] V_TIE = 2'b00;
   localparam logic [1:0] V_BAD = 2'b11;
   localparam logic [1:0] W_NONE = 2'b00;
   localparam logic [1:0] W_P2   = 2'b01;
   localparam logic [1:0] W_P1   = 2'b10;
   localparam logic [1:0] W_BOTH = 2'b11;
   typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter with synchronous clear; saturates at all-ones when SAT, else wraps.
module sat_counter #(
   parameter int W   = 4,
   parameter int SAT = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);
   logic [W-1:0] q_q, q_d;
   always_comb begin
      q_d = clr ? '0 : (inc && !(SAT != 0 && &q_q)) ? q_q + W'(1) : q_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) q_q <= '0;
      else       q_q <= q_d;
   end
   assign q = q_q;
endmodule

// File: rtl/score_keeper.sv
// score_keeper: registered two-player score keeper with tie snapshot, round count and match-end FSM.
module score_keeper
   import score_pkg::*;
#(
   parameter int CNT_W  = 4,
   parameter int TARGET = 9,
   parameter int SAT    = 1,
   parameter int EDGE   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       comp_out,
   input  logic             comp_valid,
   input  logic             clear,
   output logic [CNT_W-1:0] cnt1,
   output logic [CNT_W-1:0] cnt2,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] rounds,
   output logic [1:0]       winner,
   output logic             match_over,
   output logic             err
);
   if (TARGET > (1 << CNT_W) - 1) begin : g_bad_target
      $error("score_keeper: TARGET does not fit in CNT_W bits");
   end
   localparam logic [CNT_W-1:0] TGT = CNT_W'(TARGET);
   state_t           state_q, state_d;
   logic             valid_q, valid_d;
   logic [1:0]       winner_q, winner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             ev, acc, good, inc1, inc2, hit1, hit2;
   logic [CNT_W-1:0] cnt1_n, cnt2_n;
   // Post-update score, used only to decide match end in the same edge as the increment.
   function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
      return (!en || (SAT != 0 && &v)) ? v : v + CNT_W'(1);
   endfunction
   always_comb begin
      valid_d  = comp_valid;
      ev       = (EDGE != 0) ? comp_valid & ~valid_q : comp_valid;
      acc      = ev & (state_q == PLAY) & ~clear;
      good     = acc & (comp_out != V_BAD);
      inc1     = good & (comp_out == V_P1 || comp_out == V_TIE);
      inc2     = good & (comp_out == V_P2 || comp_out == V_TIE);
      cnt1_n   = bump(cnt1, inc1);
      cnt2_n   = bump(cnt2, inc2);
      hit1     = (TARGET != 0) && good && (cnt1_n == TGT);
      hit2     = (TARGET != 0) && good && (cnt2_n == TGT);
      state_d  = clear ? PLAY : (hit1 || hit2) ? OVER : state_q;
      winner_d = clear ? W_NONE : (hit1 || hit2) ? {hit1, hit2} : winner_q;
      cnt_d    = clear ? '0 : (good && comp_out == V_TIE) ? cnt1 : cnt_q;
      err_d    = acc & (comp_out == V_BAD);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= PLAY;
         valid_q  <= 1'b1;
         winner_q <= W_NONE;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         winner_q <= winner_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end
   sat_counter #(.W(CNT_W), .SAT(SAT)) u_cnt1 (
      .clk(clk), .reset(reset), .inc(inc1), .clr(clear), .q(cnt1)
   );
   sat_counter #(.W(CNT_W), .SAT(SAT)) u_cnt2 (
      .clk(clk), .reset(reset), .inc(inc2), .clr(clear), .q(cnt2)
   );
   sat_counter #(.W(CNT_W), .SAT(SAT)) u_rounds (
      .clk(clk), .reset(reset), .inc(good), .clr(clear), .q(rounds)
   );
   assign cnt        = cnt_q;
   assign winner     = winner_q;
   assign match_over = (state_q == OVER);
   assign err        = err_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: scoreboard bench for three score_keeper configs (default, endless saturating, endless wrapping).
module tb_score_keeper;
   import score_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [1:0] comp_out = V_TIE;
   logic comp_valid = 1'b1;
   logic clear = 1'b0;
   logic [3:0] c1 [3];
   logic [3:0] c2 [3];
   logic [3:0] cs [3];
   logic [3:0] rd [3];
   logic [1:0] wn [3];
   logic mo [3];
   logic er [3];
   int checks = 0;
   int errors = 0;
   typedef struct {int c1; int c2; int c; int r; int w; int mo; int e;} exp_t;
   exp_t sb[$];
   int m_c1[3], m_c2[3], m_c[3], m_r[3], m_w[3], m_over[3], m_err[3];
   int m_vq;
   int tgt[3] = '{9, 0, 0};
   int sat[3] = '{1, 1, 0};
   always #5 clk = ~clk;
   score_keeper u_def (
      .clk(clk), .reset(reset), .comp_out(comp_out), .comp_valid(comp_valid), .clear(clear),
      .cnt1(c1[0]), .cnt2(c2[0]), .cnt(cs[0]), .rounds(rd[0]), .winner(wn[0]),
      .match_over(mo[0]), .err(er[0])
   );
   score_keeper #(.CNT_W(4), .TARGET(0), .SAT(1), .EDGE(1)) u_sat (
      .clk(clk), .reset(reset), .comp_out(comp_out), .comp_valid(comp_valid), .clear(clear),
      .cnt1(c1[1]), .cnt2(c2[1]), .cnt(cs[1]), .rounds(rd[1]), .winner(wn[1]),
      .match_over(mo[1]), .err(er[1])
   );
   score_keeper #(.CNT_W(4), .TARGET(0), .SAT(0), .EDGE(1)) u_wrap (
      .clk(clk), .reset(reset), .comp_out(comp_out), .comp_valid(comp_valid), .clear(clear),
      .cnt1(c1[2]), .cnt2(c2[2]), .cnt(cs[2]), .rounds(rd[2]), .winner(wn[2]),
      .match_over(mo[2]), .err(er[2])
   );
   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask
   function automatic int bump(input int v, input int s);
      return s != 0 ? (v == 15 ? 15 : v + 1) : (v + 1) % 16;
   endfunction
   task automatic model_reset();
      m_vq = 1;
      for (int i = 0; i < 3; i++) begin
         m_c1[i] = 0; m_c2[i] = 0; m_c[i] = 0; m_r[i] = 0; m_w[i] = 0; m_over[i] = 0; m_err[i] = 0;
      end
   endtask
   task automatic push_all();
      for (int i = 0; i < 3; i++)
         sb.push_back('{m_c1[i], m_c2[i], m_c[i], m_r[i], m_w[i], m_over[i], m_err[i]});
   endtask
   task automatic pop_compare();
      exp_t x;
      for (int i = 0; i < 3; i++) begin
         if (sb.size() == 0) begin
            check($sformatf("i%0d scoreboard_empty", i), 0, 1);
            return;
         end
         x = sb.pop_front();
         check($sformatf("i%0d cnt1", i), int'(c1[i]), x.c1);
         check($sformatf("i%0d cnt2", i), int'(c2[i]), x.c2);
         check($sformatf("i%0d cnt", i), int'(cs[i]), x.c);
         check($sformatf("i%0d rounds", i), int'(rd[i]), x.r);
         check($sformatf("i%0d winner", i), int'(wn[i]), x.w);
         check($sformatf("i%0d match_over", i), int'(mo[i]), x.mo);
         check($sformatf("i%0d err", i), int'(er[i]), x.e);
      end
   endtask
   task automatic step(input logic v, input logic [1:0] d, input logic c);
      int ev;
      int h1, h2;
      @(negedge clk);
      comp_valid = v; comp_out = d; clear = c;
      ev = (v && !m_vq) ? 1 : 0;
      m_vq = v;
      for (int i = 0; i < 3; i++) begin
         m_err[i] = 0;
         if (c) begin
            m_c1[i] = 0; m_c2[i] = 0; m_c[i] = 0; m_r[i] = 0; m_w[i] = 0; m_over[i] = 0;
         end else if (ev != 0 && m_over[i] == 0) begin
            if (d == V_BAD) m_err[i] = 1;
            else begin
               if (d == V_TIE) m_c[i] = m_c1[i];
               if (d != V_P2) m_c1[i] = bump(m_c1[i], sat[i]);
               if (d != V_P1) m_c2[i] = bump(m_c2[i], sat[i]);
               m_r[i] = bump(m_r[i], sat[i]);
               h1 = (tgt[i] != 0 && m_c1[i] == tgt[i]) ? 1 : 0;
               h2 = (tgt[i] != 0 && m_c2[i] == tgt[i]) ? 1 : 0;
               if (h1 + h2 > 0) begin
                  m_over[i] = 1;
                  m_w[i] = h1 * 2 + h2;
               end
            end
         end
      end
      push_all();
      @(posedge clk);
      #1;
      pop_compare();
   endtask
   task automatic pulse(input logic [1:0] d);
      step(1'b1, d, 1'b0);
      step(1'b0, d, 1'b0);
   endtask
   initial begin
      model_reset();
      #3;
      push_all();
      pop_compare();
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, V_P1, 1'b0);
      step(1'b1, V_P1, 1'b0);
      check("held_valid_no_event", int'(c1[0]), 0);
      step(1'b0, V_P1, 1'b0);
      pulse(V_P1);
      pulse(V_P1);
      pulse(V_P2);
      pulse(V_TIE);
      check("seq_cnt1", int'(c1[0]), 3);
      check("seq_cnt2", int'(c2[0]), 2);
      check("seq_cnt", int'(cs[0]), 2);
      check("seq_rounds", int'(rd[0]), 4);
      step(1'b1, V_BAD, 1'b0);
      check("bad_err_pulse", int'(er[0]), 1);
      check("bad_rounds_same", int'(rd[0]), 4);
      step(1'b0, V_BAD, 1'b0);
      check("bad_err_one_cycle", int'(er[0]), 0);
      step(1'b1, V_P1, 1'b1);
      check("clear_wins_cnt1", int'(c1[0]), 0);
      check("clear_wins_rounds", int'(rd[0]), 0);
      step(1'b0, V_P1, 1'b0);
      for (int k = 0; k < 9; k++) pulse(V_P1);
      check("target_cnt1", int'(c1[0]), 9);
      check("target_winner", int'(wn[0]), 2);
      check("target_over", int'(mo[0]), 1);
      pulse(V_P2);
      check("over_cnt2", int'(c2[0]), 0);
      check("over_rounds", int'(rd[0]), 9);
      step(1'b0, V_TIE, 1'b1);
      for (int k = 0; k < 8; k++) pulse(V_TIE);
      check("pre_tie_over", int'(mo[0]), 0);
      pulse(V_TIE);
      check("tie_cnt1", int'(c1[0]), 9);
      check("tie_cnt2", int'(c2[0]), 9);
      check("tie_cnt", int'(cs[0]), 8);
      check("tie_winner", int'(wn[0]), 3);
      step(1'b0, V_P1, 1'b1);
      for (int k = 0; k < 17; k++) pulse(V_P1);
      check("sat_cnt1", int'(c1[1]), 15);
      check("sat_rounds", int'(rd[1]), 15);
      check("wrap_cnt1", int'(c1[2]), 1);
      check("wrap_rounds", int'(rd[2]), 1);
      @(negedge clk);
      comp_valid = 1'b1; comp_out = V_P2;
      reset = 1'b1;
      #2;
      model_reset();
      push_all();
      pop_compare();
      reset = 1'b0;
      step(1'b1, V_P2, 1'b0);
      check("post_reset_no_event", int'(c2[0]), 0);
      step(1'b0, V_P2, 1'b0);
      pulse(V_P2);
      check("post_reset_fresh_rise", int'(c2[0]), 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
